// File: rtl/conv_acc_pkg.sv
// Shared types, widths and saturation limits for the convolution accumulator
// and the later pooling stages.
package conv_acc_pkg;

  localparam int unsigned PIPE_DEPTH = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } tap_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tap_tag_t;

  // Accumulator wide enough that a full window of extreme products cannot overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned taps);
    return 2 * dw + int'($clog2(taps));
  endfunction

  function automatic int unsigned cnt_width(input int unsigned taps);
    return (taps > 1) ? int'($clog2(taps)) : 1;
  endfunction

  function automatic longint sat_max(input int unsigned ow);
    return (longint'(1) <<< (ow - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// Combinational arithmetic shift, signed saturation and optional ReLU.
// Define CONV_ACC_RELU_EN to clamp negative results to zero.
module conv_sat_shift
  import conv_acc_pkg::*;
#(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data_c,
  output logic                    o_sat_c
);

  localparam int unsigned EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] LIM_MAX = EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] LIM_MIN = EXT_W'(sat_min(OUT_W));

  logic signed [IN_W-1:0]  w_shifted;
  logic signed [EXT_W-1:0] w_ext;

  assign w_shifted = i_data >>> SHIFT;
  assign w_ext     = EXT_W'(w_shifted);

  always_comb begin
    o_data_c = OUT_W'(w_ext);
    o_sat_c  = 1'b0;
    if (w_ext > LIM_MAX) begin
      o_data_c = OUT_W'(LIM_MAX);
      o_sat_c  = 1'b1;
    end else if (w_ext < LIM_MIN) begin
      o_data_c = OUT_W'(LIM_MIN);
      o_sat_c  = 1'b1;
    end
`ifdef CONV_ACC_RELU_EN
    // Negative clipping is not reported once ReLU discards the sign.
    if (o_data_c[OUT_W-1]) begin
      o_data_c = '0;
      o_sat_c  = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/conv_window_acc.sv
// Convolution-window MAC: sums KERNEL_TAPS signed products per window, then
// shifts/saturates (optional ReLU via CONV_ACC_RELU_EN) and strobes Set once.
module conv_window_acc
  import conv_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_TAPS = 9,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT       = 0
) (
  input  logic                         CONV_ACC_Clk,
  input  logic                         CONV_ACC_Reset,
  input  logic                         CONV_ACC_Clear,
  input  logic                         CONV_ACC_Valid,
  input  logic signed [DATA_WIDTH-1:0] CONV_ACC_Pixel,
  input  logic signed [DATA_WIDTH-1:0] CONV_ACC_Weight,
  output logic signed [OUT_WIDTH-1:0]  CONV_ACC_Output_Data,
  output logic                         CONV_ACC_Set,
  output logic                         CONV_ACC_Sat,
  output logic                         CONV_ACC_Busy
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, KERNEL_TAPS);
  localparam int unsigned CNT_W  = cnt_width(KERNEL_TAPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_TAPS - 1);

  tap_state_e              r_state;
  tap_state_e              w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  tap_tag_t                w_tap_tag;

  tap_tag_t                r_s0_tag;
  logic signed [DATA_WIDTH-1:0] r_s0_pix;
  logic signed [DATA_WIDTH-1:0] r_s0_wgt;
  tap_tag_t                r_s1_tag;
  logic signed [PROD_W-1:0] r_s1_prod;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_s2_pend;
  logic signed [OUT_WIDTH-1:0] r_out;
  logic                     r_sat;
  logic                     r_set;
  logic                     r_busy;
  logic signed [OUT_WIDTH-1:0] w_res;
  logic                     w_res_sat;

  // Tap counter state register.
  always_ff @(posedge CONV_ACC_Clk) begin
    if (!CONV_ACC_Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state: Clear aborts the window and drops any tap offered with it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (CONV_ACC_Clear) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else if (CONV_ACC_Valid) begin
      if (r_cnt == LAST_CNT) begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end else begin
        w_state_next = ST_ACCUM;
        w_cnt_next   = r_cnt + CNT_W'(1);
      end
    end
  end

  // Tap tags for the accepted input.
  always_comb begin
    w_tap_tag       = '0;
    w_tap_tag.valid = CONV_ACC_Valid & ~CONV_ACC_Clear;
    w_tap_tag.first = (r_state == ST_IDLE);
    w_tap_tag.last  = (r_cnt == LAST_CNT);
  end

  assign w_prod = PROD_W'(r_s0_pix) * PROD_W'(r_s0_wgt);

  // Input capture, product, accumulate and output stages.
  always_ff @(posedge CONV_ACC_Clk) begin
    if (!CONV_ACC_Reset) begin
      r_s0_tag  <= '0;
      r_s0_pix  <= '0;
      r_s0_wgt  <= '0;
      r_s1_tag  <= '0;
      r_s1_prod <= '0;
      r_acc     <= '0;
      r_s2_pend <= 1'b0;
      r_out     <= '0;
      r_sat     <= 1'b0;
      r_set     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_s0_tag <= w_tap_tag;
      if (w_tap_tag.valid) begin
        r_s0_pix <= CONV_ACC_Pixel;
        r_s0_wgt <= CONV_ACC_Weight;
      end
      r_s1_tag <= CONV_ACC_Clear ? '0 : r_s0_tag;
      if (r_s0_tag.valid) begin
        r_s1_prod <= w_prod;
      end
      // First-tagged product reloads so back-to-back windows never mix.
      if (r_s1_tag.valid) begin
        r_acc <= r_s1_tag.first ? ACC_W'(r_s1_prod) : r_acc + ACC_W'(r_s1_prod);
      end
      r_s2_pend <= ~CONV_ACC_Clear & r_s1_tag.valid & r_s1_tag.last;
      r_set     <= r_s2_pend;
      if (r_s2_pend) begin
        r_out <= w_res;
        r_sat <= w_res_sat;
      end
      r_busy <= (w_cnt_next != '0) | w_tap_tag.valid
              | (~CONV_ACC_Clear & r_s0_tag.valid)
              | (~CONV_ACC_Clear & r_s1_tag.valid & r_s1_tag.last);
    end
  end

  conv_sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_WIDTH),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .i_data   (r_acc),
    .o_data_c (w_res),
    .o_sat_c  (w_res_sat)
  );

  assign CONV_ACC_Output_Data = r_out;
  assign CONV_ACC_Set         = r_set;
  assign CONV_ACC_Sat         = r_sat;
  assign CONV_ACC_Busy        = r_busy;

endmodule

// File: tb/tb_conv_window_acc.sv
// Bench for conv_window_acc: directed windows plus random traffic checked
// against an event-list reference model (default and 12-bit output instances).
module tb_conv_window_acc;
  import conv_acc_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned TAPS = 9;
  localparam int unsigned OW   = 16;
  localparam int unsigned OW_N = 12;
  localparam int unsigned SH   = 0;

`ifdef CONV_ACC_RELU_EN
  localparam longint T2N_A = 0;
  localparam longint T2N_B = 0;
  localparam longint T2N_S = 0;
  localparam longint T6_D  = 0;
`else
  localparam longint T2N_A = -32768;
  localparam longint T2N_B = -2048;
  localparam longint T2N_S = 1;
  localparam longint T6_D  = -9;
`endif

  logic clk, rst_n, clr, vld;
  logic signed [DW-1:0]   pix, wgt;
  logic signed [OW-1:0]   data_a;
  logic                   set_a, sat_a, busy_a;
  logic signed [OW_N-1:0] data_b;
  logic                   set_b, sat_b, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  conv_window_acc #(.DATA_WIDTH(DW), .KERNEL_TAPS(TAPS), .OUT_WIDTH(OW), .SHIFT(SH)) u_dut (
    .CONV_ACC_Clk(clk), .CONV_ACC_Reset(rst_n), .CONV_ACC_Clear(clr), .CONV_ACC_Valid(vld),
    .CONV_ACC_Pixel(pix), .CONV_ACC_Weight(wgt), .CONV_ACC_Output_Data(data_a),
    .CONV_ACC_Set(set_a), .CONV_ACC_Sat(sat_a), .CONV_ACC_Busy(busy_a)
  );

  conv_window_acc #(.DATA_WIDTH(DW), .KERNEL_TAPS(TAPS), .OUT_WIDTH(OW_N), .SHIFT(SH)) u_dut_n (
    .CONV_ACC_Clk(clk), .CONV_ACC_Reset(rst_n), .CONV_ACC_Clear(clr), .CONV_ACC_Valid(vld),
    .CONV_ACC_Pixel(pix), .CONV_ACC_Weight(wgt), .CONV_ACC_Output_Data(data_b),
    .CONV_ACC_Set(set_b), .CONV_ACC_Sat(sat_b), .CONV_ACC_Busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each accepted tap is an event stamped with its sample edge.
  typedef struct {
    int     j;
    bit     is_last;
    longint sum;
  } rec_t;

  rec_t   recs[$];
  int     edge_k = 0;
  bit     started = 1'b0;
  int     win_cnt = 0;
  longint win_sum = 0;
  bit     exp_set = 1'b0;
  bit     exp_busy = 1'b0;
  longint exp_data_a = 0, exp_data_b = 0;
  bit     exp_sat_a = 1'b0, exp_sat_b = 1'b0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_k, got, exp);
    end
  endtask

  function automatic void ref_result(input longint sum, input int unsigned ow,
                                     output longint d, output bit s);
    longint v, hi, lo;
    v  = sum >>> SH;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    d  = v;
    s  = 1'b0;
    if (v > hi) begin d = hi; s = 1'b1; end
    else if (v < lo) begin d = lo; s = 1'b1; end
`ifdef CONV_ACC_RELU_EN
    if (d < 0) begin d = 0; s = 1'b0; end
`endif
  endfunction

  task automatic model_step();
    rec_t r;
    edge_k++;
    started = 1'b1;
    exp_set = 1'b0;
    if (!rst_n) begin
      recs.delete();
      win_cnt = 0; win_sum = 0;
      exp_data_a = 0; exp_data_b = 0; exp_sat_a = 1'b0; exp_sat_b = 1'b0;
      exp_busy = 1'b0;
      return;
    end
    foreach (recs[i]) begin
      if (recs[i].is_last && recs[i].j == edge_k - int'(PIPE_DEPTH)) begin
        exp_set = 1'b1;
        ref_result(recs[i].sum, OW, exp_data_a, exp_sat_a);
        ref_result(recs[i].sum, OW_N, exp_data_b, exp_sat_b);
      end
    end
    if (clr) begin
      for (int i = recs.size() - 1; i >= 0; i--)
        if (recs[i].j >= edge_k - 2) recs.delete(i);
      win_cnt = 0; win_sum = 0;
    end else if (vld) begin
      win_sum += longint'(pix) * longint'(wgt);
      win_cnt++;
      r.j = edge_k;
      r.is_last = (win_cnt == TAPS);
      r.sum = r.is_last ? win_sum : 0;
      recs.push_back(r);
      if (r.is_last) begin win_cnt = 0; win_sum = 0; end
    end
    for (int i = recs.size() - 1; i >= 0; i--)
      if (recs[i].j < edge_k - 2) recs.delete(i);
    exp_busy = (win_cnt != 0);
    foreach (recs[i])
      if (recs[i].j >= edge_k - 1 || recs[i].is_last) exp_busy = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check_val("set_a",  64'(set_a),  64'(exp_set));
      check_val("set_b",  64'(set_b),  64'(exp_set));
      check_val("data_a", 64'(data_a), exp_data_a);
      check_val("data_b", 64'(data_b), exp_data_b);
      check_val("sat_a",  64'(sat_a),  64'(exp_sat_a));
      check_val("sat_b",  64'(sat_b),  64'(exp_sat_b));
      check_val("busy_a", 64'(busy_a), 64'(exp_busy));
      check_val("busy_b", 64'(busy_b), 64'(exp_busy));
    end
  end

  task automatic drive(input bit r, input bit c, input bit v, input int p, input int w);
    rst_n = r; clr = c; vld = v;
    pix = DW'(p); wgt = DW'(w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic window(input int p, input int w);
    repeat (TAPS) drive(1'b1, 1'b0, 1'b1, p, w);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; vld = 1'b0; pix = '0; wgt = '0;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 5, 5);
    check_val("rst_data", 64'(data_a), 64'sd0);
    check_val("rst_busy", 64'(busy_a), 64'sd0);

    for (int i = 1; i <= int'(TAPS); i++) drive(1'b1, 1'b0, 1'b1, 1, i);
    idle(5);
    check_val("t1_data", 64'(data_a), 64'sd45);
    check_val("t1_sat",  64'(sat_a),  64'sd0);

    window(127, 127);
    idle(5);
    check_val("t2p_a", 64'(data_a), 64'sd32767);
    check_val("t2p_b", 64'(data_b), 64'sd2047);
    check_val("t2p_sat", 64'(sat_b), 64'sd1);
    window(127, -128);
    idle(5);
    check_val("t2n_a", 64'(data_a), T2N_A);
    check_val("t2n_b", 64'(data_b), T2N_B);
    check_val("t2n_sat", 64'(sat_b), T2N_S);

    window(2, 3);
    window(-1, 1);
    idle(6);
    check_val("t3_data", 64'(data_a), T6_D);

    repeat (4) drive(1'b1, 1'b0, 1'b1, 1, 1);
    drive(1'b1, 1'b1, 1'b1, 100, 100);
    window(1, 1);
    idle(6);
    check_val("t4_data", 64'(data_a), 64'sd9);
    window(5, 5);
    drive(1'b1, 1'b1, 1'b0, 0, 0);
    idle(6);
    check_val("t4_inflight", 64'(data_a), 64'sd9);
    window(1, 3);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, 0, 0);
    idle(4);
    check_val("t4_s3_kept", 64'(data_a), 64'sd27);

    repeat (4) drive(1'b1, 1'b0, 1'b1, 3, 3);
    drive(1'b0, 1'b0, 1'b1, 3, 3);
    idle(6);
    check_val("t5_data", 64'(data_a), 64'sd0);
    window(1, 2);
    idle(6);
    check_val("t5_fresh", 64'(data_a), 64'sd18);

    window(7, 7);
    window(-1, 1);
    idle(6);
    check_val("t6_data", 64'(data_a), T6_D);
    check_val("t6_sat",  64'(sat_a),  64'sd0);

    // Random traffic with gaps, occasional clears and rare resets.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 299) != 0,
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
